alarm_controller: RTL and testbench

//   Lights-on warning controller for the alarm example. Consumes the light, door and ignition

---
 rtl/alarm_controller.sv | 122 ++++++++++++
 tb/tb_alarm_controller.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Lights-on warning controller: debounces the "lights on, door open, ignition off"
// condition, then drives a periodic beep on sAlarm until a timeout mutes it.
module alarm_controller #(
  parameter int DEBOUNCE = 4,
  parameter int BEEP_ON  = 3,
  parameter int BEEP_OFF = 3,
  parameter int TIMEOUT  = 64,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sLuz,
  input  logic       sPrta,
  input  logic       sIgn,
  output logic       sAlarm,
  output logic [1:0] alarm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    BEEP = 2'b10,
    MUTE = 2'b11
  } state_t;

  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] ZERO       = '0;
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] PERIOD_END = CW'(BEEP_ON + BEEP_OFF - 1);
  localparam logic [CW-1:0] ON_LEN     = CW'(BEEP_ON);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);

  state_t        state, stateNext;
  logic [CW-1:0] qcnt, qcntNext;
  logic [CW-1:0] pcnt, pcntNext;
  logic [CW-1:0] tcnt, tcntNext;
  logic          sAlarmNext;
  logic          cond;

  assign cond        = sLuz & sPrta & ~sIgn;
  assign alarm_state = state;

  // State, counters and the beeper output register; async reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      qcnt   <= ZERO;
      pcnt   <= ZERO;
      tcnt   <= ZERO;
      sAlarm <= 1'b0;
    end else begin
      state  <= stateNext;
      qcnt   <= qcntNext;
      pcnt   <= pcntNext;
      tcnt   <= tcntNext;
      sAlarm <= sAlarmNext;
    end
  end

  // Next-state and counter update; any drop of cond returns to IDLE with counters cleared.
  always_comb begin
    stateNext = state;
    qcntNext  = qcnt;
    pcntNext  = pcnt;
    tcntNext  = tcnt;
    unique case (state)
      IDLE: begin
        if (cond) begin
          stateNext = ARM;
          qcntNext  = ONE;
        end
      end
      ARM: begin
        if (!cond) begin
          stateNext = IDLE;
          qcntNext  = ZERO;
        end else if (qcnt == DEB_LAST) begin
          stateNext = BEEP;
          qcntNext  = ZERO;
          pcntNext  = ZERO;
          tcntNext  = ZERO;
        end else begin
          qcntNext  = qcnt + ONE;
        end
      end
      BEEP: begin
        if (!cond) begin
          // Clearing wins over the timeout.
          stateNext = IDLE;
          qcntNext  = ZERO;
          pcntNext  = ZERO;
          tcntNext  = ZERO;
        end else if (tcnt == TMO_LAST) begin
          stateNext = MUTE;
        end else begin
          tcntNext  = tcnt + ONE;
          pcntNext  = (pcnt == PERIOD_END) ? ZERO : pcnt + ONE;
        end
      end
      MUTE: begin
        if (!cond) begin
          stateNext = IDLE;
          qcntNext  = ZERO;
          pcntNext  = ZERO;
          tcntNext  = ZERO;
        end
      end
      default: begin
        stateNext = IDLE;
        qcntNext  = ZERO;
        pcntNext  = ZERO;
        tcntNext  = ZERO;
      end
    endcase
  end

  // Beeper level for the next cycle, computed from next-state values so sAlarm stays registered.
  always_comb begin
    sAlarmNext = (stateNext == BEEP) && (pcntNext < ON_LEN);
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios followed by randomized sensor traffic,
// all checked against a run-length based reference model.
module tb_alarm_controller;

  localparam int DEB  = 4;
  localparam int BON  = 3;
  localparam int BOFF = 3;
  localparam int TMO  = 64;
  localparam int CW   = 8;

  logic       clk;
  logic       reset;
  logic       sLuz;
  logic       sPrta;
  logic       sIgn;
  logic       sAlarm;
  logic [1:0] alarm_state;

  int nChecks = 0;
  int nFail   = 0;
  // Reference: number of consecutive rising edges at which cond was 1 (0 after reset).
  int runLen  = 0;

  alarm_controller #(
    .DEBOUNCE(DEB),
    .BEEP_ON (BON),
    .BEEP_OFF(BOFF),
    .TIMEOUT (TMO),
    .CW      (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sLuz       (sLuz),
    .sPrta      (sPrta),
    .sIgn       (sIgn),
    .sAlarm     (sAlarm),
    .alarm_state(alarm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs from the current run length: ARM while debouncing, then BEEP for
  // TMO cycles with an on/off pattern by cycle index, then MUTE.
  function automatic logic [1:0] expState(input int n);
    if (n == 0)              return 2'b00;
    else if (n < DEB)        return 2'b01;
    else if (n - DEB < TMO)  return 2'b10;
    else                     return 2'b11;
  endfunction

  function automatic logic expAlarm(input int n);
    if (n < DEB || n - DEB >= TMO) return 1'b0;
    return ((n - DEB) % (BON + BOFF)) < BON;
  endfunction

  task automatic checkOut(input string tag);
    logic [1:0] es;
    logic       ea;
    es = expState(runLen);
    ea = expAlarm(runLen);
    nChecks++;
    assert (alarm_state === es) else begin
      nFail++;
      $error("FAIL %s alarm_state observed=%0b expected=%0b (run=%0d)", tag, alarm_state, es, runLen);
    end
    nChecks++;
    assert (sAlarm === ea) else begin
      nFail++;
      $error("FAIL %s sAlarm observed=%0b expected=%0b (run=%0d)", tag, sAlarm, ea, runLen);
    end
  endtask

  // Apply levels, take one rising edge, update the model, check at the falling edge.
  task automatic step(input logic l, input logic p, input logic i, input string tag);
    sLuz  = l;
    sPrta = p;
    sIgn  = i;
    @(posedge clk);
    if (l & p & ~i) runLen++;
    else            runLen = 0;
    @(negedge clk);
    checkOut(tag);
  endtask

  // Asynchronous reset pulse between edges, checked before any clock edge.
  task automatic pulseReset(input string tag);
    #1;
    reset = 1'b1;
    #1;
    runLen = 0;
    checkOut(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sLuz  = 1'b0;
    sPrta = 1'b0;
    sIgn  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    runLen = 0;
    checkOut("reset_hold");

    // Reset asserted between edges acts at once; idle inputs keep IDLE afterwards.
    reset = 1'b0;
    step(1, 1, 0, "pre_reset_arm");
    pulseReset("reset_async");
    for (int k = 0; k < 3; k++) step(0, 0, 0, "idle_hold");

    // Basic debounce and beep pattern.
    for (int k = 0; k < 14; k++) step(1, 1, 0, "basic");
    step(0, 1, 0, "basic_clear");

    // Ignition on suppresses the warning; dropping it starts the debounce.
    for (int k = 0; k < 20; k++) step(1, 1, 1, "ignition_on");
    for (int k = 0; k < 6; k++) step(1, 1, 0, "ignition_off");
    step(0, 0, 0, "ignition_clear");

    // Glitch during debounce.
    for (int k = 0; k < 3; k++) step(1, 1, 0, "glitch_arm");
    step(1, 1, 1, "glitch_drop");
    for (int k = 0; k < 3; k++) step(0, 0, 0, "glitch_idle");

    // Timeout into MUTE, clear via door, re-debounce.
    for (int k = 0; k < 80; k++) step(1, 1, 0, "timeout");
    step(1, 0, 0, "mute_clear");
    for (int k = 0; k < 6; k++) step(1, 1, 0, "rearm");

    // Mid-beep reset, then re-debounce.
    step(0, 0, 0, "pre_mid");
    for (int k = 0; k < 4; k++) step(1, 1, 0, "mid_beep");
    pulseReset("mid_reset");
    for (int k = 0; k < 6; k++) step(1, 1, 0, "mid_redebounce");

    // Lights off mid-beep clears after one edge.
    step(0, 1, 0, "lights_off");
    step(0, 1, 0, "lights_off_hold");

    // Random traffic with frequent drops.
    for (int k = 0; k < 300; k++)
      step(($urandom % 12) != 0, ($urandom % 12) != 0, ($urandom % 10) == 0, "rand_short");
    // Random traffic with rare drops so long beeps and mutes occur.
    for (int k = 0; k < 500; k++)
      step(($urandom % 90) != 0, ($urandom % 90) != 0, ($urandom % 90) == 0, "rand_long");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
